// File: rtl/id_ex_register_pkg.sv
// Shared decode constants and the ID/EX control payload.
package id_ex_register_pkg;

  localparam int unsigned NB_EXT_MODE = 2;
  localparam int unsigned NB_OPCODE   = 6;
  localparam int unsigned NB_FUNCT    = 6;

  // Immediate extension modes
  localparam logic [NB_EXT_MODE-1:0] EXT_ZERO = 2'd0;
  localparam logic [NB_EXT_MODE-1:0] EXT_SIGN = 2'd1;
  localparam logic [NB_EXT_MODE-1:0] EXT_LUI  = 2'd2;

  // Memory access size codes; NONE is what a bubble carries
  localparam int unsigned WORD_SIZE_NONE = 0;
  localparam int unsigned WORD_SIZE_BYTE = 1;
  localparam int unsigned WORD_SIZE_HALF = 2;
  localparam int unsigned WORD_SIZE_WORD = 3;

  typedef struct packed {
    logic alu_src;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic branch;
    logic jump;
  } ctrl_t;

endpackage

// File: rtl/id_ex_register_if.sv
// Decode-to-execute bus: decode-side fields in, latched execute-side fields out.
interface id_ex_register_if
  import id_ex_register_pkg::*;
#(
  parameter int unsigned NB_DATA      = 32,
  parameter int unsigned NB_REG       = 5,
  parameter int unsigned NB_SIZE_TYPE = 3,
  parameter int unsigned NB_CNT       = 16
);
  logic                    i_step, i_flush, i_valid;
  logic                    i_ALUSrc, i_mem_read, i_mem_write, i_reg_write, i_branch, i_jump;
  logic [NB_EXT_MODE-1:0]  i_ExtensionMode;
  logic [NB_SIZE_TYPE-1:0] i_word_size;
  logic [NB_OPCODE-1:0]    i_opcode;
  logic [NB_FUNCT-1:0]     i_funct;
  logic [NB_DATA-1:0]      i_pc, i_rs_data, i_rt_data, i_imm_ext;
  logic [NB_REG-1:0]       i_rs, i_rt, i_rd;

  logic                    o_valid;
  logic                    o_ALUSrc, o_mem_read, o_mem_write, o_reg_write, o_branch, o_jump;
  logic [NB_EXT_MODE-1:0]  o_ExtensionMode;
  logic [NB_SIZE_TYPE-1:0] o_word_size;
  logic [NB_OPCODE-1:0]    o_opcode;
  logic [NB_FUNCT-1:0]     o_funct;
  logic [NB_DATA-1:0]      o_pc, o_rs_data, o_rt_data, o_imm_ext;
  logic [NB_REG-1:0]       o_rs, o_rt, o_rd;
  logic                    o_load_use_stall;
  logic [NB_CNT-1:0]       o_bubble_count;

  modport master (
    output i_step, i_flush, i_valid,
    output i_ALUSrc, i_mem_read, i_mem_write, i_reg_write, i_branch, i_jump,
    output i_ExtensionMode, i_word_size, i_opcode, i_funct,
    output i_pc, i_rs_data, i_rt_data, i_imm_ext, i_rs, i_rt, i_rd,
    input  o_valid, o_ALUSrc, o_mem_read, o_mem_write, o_reg_write, o_branch, o_jump,
    input  o_ExtensionMode, o_word_size, o_opcode, o_funct,
    input  o_pc, o_rs_data, o_rt_data, o_imm_ext, o_rs, o_rt, o_rd,
    input  o_load_use_stall, o_bubble_count
  );

  modport slave (
    input  i_step, i_flush, i_valid,
    input  i_ALUSrc, i_mem_read, i_mem_write, i_reg_write, i_branch, i_jump,
    input  i_ExtensionMode, i_word_size, i_opcode, i_funct,
    input  i_pc, i_rs_data, i_rt_data, i_imm_ext, i_rs, i_rt, i_rd,
    output o_valid, o_ALUSrc, o_mem_read, o_mem_write, o_reg_write, o_branch, o_jump,
    output o_ExtensionMode, o_word_size, o_opcode, o_funct,
    output o_pc, o_rs_data, o_rt_data, o_imm_ext, o_rs, o_rt, o_rd,
    output o_load_use_stall, o_bubble_count
  );
endinterface

// File: rtl/id_ex_register_load_use_detector.sv
// Flags a decode entry that reads the destination of a load sitting in EX.
module load_use_detector #(
  parameter int unsigned NB_REG = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [NB_REG-1:0] ex_rt,
  input  logic              id_valid,
  input  logic [NB_REG-1:0] id_rs,
  input  logic [NB_REG-1:0] id_rt,
  output logic              stall_c
);
  // Register 0 is hardwired, so a load into it never creates a hazard
  assign stall_c = ex_valid && ex_mem_read && id_valid && (ex_rt != '0) &&
                   ((ex_rt == id_rs) || (ex_rt == id_rt));
endmodule

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating bubble counter.
module id_ex_register
  import id_ex_register_pkg::*;
#(
  parameter int unsigned NB_DATA      = 32,
  parameter int unsigned NB_REG       = 5,
  parameter int unsigned NB_SIZE_TYPE = 3,
  parameter int unsigned NB_CNT       = 16
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  id_ex_register_if.slave bus
);
  logic                    valid_q;
  ctrl_t                   ctrl_q;
  ctrl_t                   ctrl_in;
  logic [NB_EXT_MODE-1:0]  ext_mode_q;
  logic [NB_SIZE_TYPE-1:0] word_size_q;
  logic [NB_OPCODE-1:0]    opcode_q;
  logic [NB_FUNCT-1:0]     funct_q;
  logic [NB_DATA-1:0]      pc_q, rs_data_q, rt_data_q, imm_q;
  logic [NB_REG-1:0]       rs_q, rt_q, rd_q;
  logic [NB_CNT-1:0]       bubble_q;
  logic                    stall_c;
  logic                    bubble_c;
  logic                    count_c;

  load_use_detector #(.NB_REG(NB_REG)) u_load_use_detector (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rt       (rt_q),
    .id_valid    (bus.i_valid),
    .id_rs       (bus.i_rs),
    .id_rt       (bus.i_rt),
    .stall_c     (stall_c)
  );

  assign ctrl_in = '{alu_src:   bus.i_ALUSrc,
                     mem_read:  bus.i_mem_read,
                     mem_write: bus.i_mem_write,
                     reg_write: bus.i_reg_write,
                     branch:    bus.i_branch,
                     jump:      bus.i_jump};

  // Flush wins over stall; only stall bubbles are counted
  assign bubble_c = bus.i_flush || stall_c;
  assign count_c  = !bus.i_flush && stall_c && (bubble_q != '1);

  // Bubbles clear valid and control only; datapath fields keep their last value
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= '0;
      ext_mode_q  <= EXT_ZERO;
      word_size_q <= NB_SIZE_TYPE'(WORD_SIZE_NONE);
      opcode_q    <= '0;
      funct_q     <= '0;
      pc_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      bubble_q    <= '0;
    end else if (bus.i_step) begin
      if (bubble_c) begin
        valid_q     <= 1'b0;
        ctrl_q      <= '0;
        word_size_q <= NB_SIZE_TYPE'(WORD_SIZE_NONE);
      end else begin
        valid_q     <= bus.i_valid;
        ctrl_q      <= bus.i_valid ? ctrl_in : '0;
        ext_mode_q  <= bus.i_ExtensionMode;
        word_size_q <= bus.i_word_size;
        opcode_q    <= bus.i_opcode;
        funct_q     <= bus.i_funct;
        pc_q        <= bus.i_pc;
        rs_data_q   <= bus.i_rs_data;
        rt_data_q   <= bus.i_rt_data;
        imm_q       <= bus.i_imm_ext;
        rs_q        <= bus.i_rs;
        rt_q        <= bus.i_rt;
        rd_q        <= bus.i_rd;
      end
      if (count_c) begin
        bubble_q <= bubble_q + NB_CNT'(1);
      end
    end
  end

  assign bus.o_valid          = valid_q;
  assign bus.o_ALUSrc         = ctrl_q.alu_src;
  assign bus.o_mem_read       = ctrl_q.mem_read;
  assign bus.o_mem_write      = ctrl_q.mem_write;
  assign bus.o_reg_write      = ctrl_q.reg_write;
  assign bus.o_branch         = ctrl_q.branch;
  assign bus.o_jump           = ctrl_q.jump;
  assign bus.o_ExtensionMode  = ext_mode_q;
  assign bus.o_word_size      = word_size_q;
  assign bus.o_opcode         = opcode_q;
  assign bus.o_funct          = funct_q;
  assign bus.o_pc             = pc_q;
  assign bus.o_rs_data        = rs_data_q;
  assign bus.o_rt_data        = rt_data_q;
  assign bus.o_imm_ext        = imm_q;
  assign bus.o_rs             = rs_q;
  assign bus.o_rt             = rt_q;
  assign bus.o_rd             = rd_q;
  assign bus.o_load_use_stall = stall_c;
  assign bus.o_bubble_count   = bubble_q;

endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 SHALL have parameter NB_DATA, default 32, datapath/PC width.
REQ-002 SHALL have parameter NB_REG, default 5, register-index width.
REQ-003 SHALL have parameter NB_SIZE_TYPE, default 3, word-size code width.
REQ-004 SHALL have parameter NB_CNT, default 16, bubble-counter width.
REQ-005 i_clk  in  1  sole clock, rising edge.
REQ-006 i_rst_n  in  1  asynchronous, active-low reset.
REQ-007 i_step  in  1  pipeline advance enable (debug single-step or run).
REQ-008 i_flush  in  1  squash incoming decode entry (taken branch/jump).
REQ-009 i_valid  in  1  decode entry valid.
REQ-010 i_ALUSrc, i_mem_read, i_mem_write, i_reg_write, i_branch, i_jump  in  1 each  decode control flags.
REQ-011 i_ExtensionMode  in  2;  i_word_size  in  NB_SIZE_TYPE;  i_opcode, i_funct  in  6 each.
REQ-012 i_pc, i_rs_data, i_rt_data, i_imm_ext  in  NB_DATA each.
REQ-013 i_rs, i_rt, i_rd  in  NB_REG each.
REQ-014 o_* outputs mirror every i_* field of REQ-010..REQ-013, same widths, registered.
REQ-015 o_valid  out  1  latched entry valid.
REQ-016 o_load_use_stall  out  1  combinational stall request to PC and IF/ID.
REQ-017 o_bubble_count  out  NB_CNT  saturating count of inserted bubbles.

Function
REQ-018 o_load_use_stall SHALL be 1 iff o_valid & o_mem_read & i_valid & (o_rt != 0) & ((o_rt == i_rs) | (o_rt == i_rt)), and 0 otherwise.
REQ-019 With i_step=0, all registers SHALL hold; o_load_use_stall stays combinational.
REQ-020 With i_step=1 and i_flush=1: bubble SHALL be latched (o_valid=0, all six control flags 0, o_word_size 0); flush has priority over stall.
REQ-021 With i_step=1, i_flush=0, o_load_use_stall=1: bubble SHALL be latched exactly as REQ-020.
REQ-022 With i_step=1, no flush, no stall: all i_* fields SHALL be captured, o_valid <= i_valid; when i_valid=0 control flags SHALL be forced to 0.
REQ-023 Latency SHALL be one i_step-qualified clock edge from input to output.
REQ-024 Datapath fields (pc, data, imm, indices, opcode, funct) during a bubble SHALL retain previous values; only valid and control flags clear.
REQ-025 o_bubble_count SHALL increment by 1 on each edge where REQ-021 applies, saturate at all-ones, and not count flush bubbles.
REQ-026 A load-use stall SHALL last exactly one step: after the bubble, o_valid=0 forces o_load_use_stall=0.

Reset
REQ-027 While i_rst_n=0, asynchronously: o_valid=0, all control flags 0, o_ExtensionMode 0, o_word_size 0, all data/index/opcode/funct fields 0, o_bubble_count 0.
REQ-028 Reset mid-stall SHALL drop o_load_use_stall to 0 immediately (follows from o_valid=0).
REQ-029 First capture SHALL occur on the first rising edge with i_rst_n=1 and i_step=1.

Structure
REQ-030 Extension-mode and word-size codes SHALL come from the shared decode constants header; no local redefinitions.
REQ-031 Load-use detection SHALL be a sub-module, load_use_detector, purely combinational, instantiated once.
REQ-032 Register bank SHALL be one always block with async reset; no latches.

Verification
REQ-033 Reset then i_step=1, ADDI entry (i_reg_write=1, i_rt=5, i_imm_ext=0x0000000A) -> next edge o_valid=1, o_reg_write=1, o_rt=5, o_imm_ext=0x0000000A.
REQ-034 Latched load (o_mem_read=1, o_rt=8), incoming i_rs=8 -> o_load_use_stall=1; next step o_valid=0, o_mem_read=0, o_bubble_count=1, stall deasserts.
REQ-035 Latched load o_rt=0, incoming i_rs=0 -> o_load_use_stall=0, entry captured normally.
REQ-036 Stall condition plus i_flush=1 -> bubble latched, o_bubble_count unchanged.
REQ-037 i_step=0 for 5 cycles with changing inputs -> all outputs constant; o_bubble_count at 0xFFFF plus stall bubble -> stays 0xFFFF.
REQ-038 i_rst_n pulsed low mid-cycle during stall -> outputs zero and o_load_use_stall=0 before next clock edge.
